// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU accumulator sequencer: FSM state encoding,
// default datapath width and settle-counter width.
package alu_seq_pkg;

    localparam int ALU_SEQ_WIDTH = 5;
    localparam int CNT_W         = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage : alu_seq_pkg

// File: rtl/alu_acc_sequencer.sv
// Chains operations through an external combinational ALU, feeding the accumulator back as operand A.
// Optional registered zero flag on the accumulator: define ALU_SEQ_ZERO_FLAG_EN.
module alu_acc_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = ALU_SEQ_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [1:0]       cmd_sel,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_last,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic             busy,
    output logic             res_zero
`else
    output logic             busy
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         sel_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               last_q;

    logic               cmd_accept;
    logic               capture;
    logic               acc_wr;
    logic [WIDTH-1:0]   acc_nxt;

    assign cmd_accept = (state_q == IDLE) && cmd_valid;
    assign capture    = (state_q == WAIT) && (cnt_q == '0);

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        acc_wr  = 1'b0;
        acc_nxt = alu_out;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_load) begin
                        acc_wr  = 1'b1;
                        acc_nxt = cmd_data;
                        state_d = cmd_last ? RESULT : IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (capture) begin
                    acc_wr  = 1'b1;
                    state_d = last_q ? RESULT : IDLE;
                end
            end
            RESULT: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (acc_wr) acc_q <= acc_nxt;
            if (cmd_accept && !cmd_load) begin
                b_q    <= cmd_data;
                sel_q  <= cmd_sel;
                cnt_q  <= SETTLE_INIT;
                last_q <= cmd_last;
            end
            if ((state_q == WAIT) && (cnt_q != '0)) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    // Tracks the value being written so the flag is aligned with acc_q.
    always_ff @(posedge clk) begin
        if (rst)         res_zero <= 1'b1;
        else if (acc_wr) res_zero <= (acc_nxt == '0);
    end
`endif

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == RESULT);
    assign res_data  = acc_q;
    assign alu_a     = acc_q;
    assign alu_b     = b_q;
    assign alu_sel   = sel_q;

endmodule : alu_acc_sequencer

// File: doc/alu_acc_sequencer.md
# alu_acc_sequencer

Upstream/downstream companion of the 5-bit ALU datapath: accepts a stream of operand commands over a valid/ready handshake and drives the ALU's A, B and select inputs. It captures the ALU's combinational result into an internal accumulator and feeds it back as the next A operand. On the command marked last, it presents the accumulator as a result with its own valid/ready handshake. Turns the purely combinational ALU into a multi-operation chained calculator with defined latency.

## Interface
- WIDTH, 5: datapath width; must match the ALU operand width.
- SETTLE, 1: cycles ALU ports are held before capture; legal range 1..7.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high exactly in IDLE.
- cmd_load  in  1  1 = load cmd_data into the accumulator directly, bypassing the ALU.
- cmd_sel  in  2  ALU select for this operation; passed through unmodified.
- cmd_data  in  WIDTH  B operand (or load value).
- cmd_last  in  1  final command of a chain; the result is presented after it completes.
- alu_a  out  WIDTH  accumulator register, to ALU inp_A.
- alu_b  out  WIDTH  registered B operand, to ALU inp_B.
- alu_sel  out  2  registered select, to ALU select.
- alu_out  in  WIDTH  ALU result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  WIDTH  accumulator value; meaningful only while res_valid is high.
- busy  out  1  high in any state other than IDLE.
- res_zero  out  1  present only with ALU_SEQ_ZERO_FLAG_EN.

## Operation
- States: IDLE, WAIT, RESULT.
- **IDLE:** cmd_ready = 1.
  - On accept of a command with cmd_load = 1: acc <= cmd_data; next state is RESULT if cmd_last, else IDLE.
  - On accept of a command with cmd_load = 0: alu_b <= cmd_data, alu_sel <= cmd_sel, cnt <= SETTLE-1, last_q <= cmd_last; next state WAIT.
- **WAIT:** cmd_ready = 0; alu_a, alu_b and alu_sel are held stable.
  - cnt != 0: cnt decrements.
  - cnt == 0: acc <= alu_out; next state is RESULT if last_q, else IDLE.
- **RESULT:** res_valid = 1 and res_data = acc; both hold until res_valid && res_ready, then next state IDLE. The accumulator is retained, so a later chain may continue from it. A restart uses cmd_load.
- Arithmetic: the accumulator is exactly WIDTH bits. Any carry is the ALU's concern and is discarded here. The block never interprets cmd_sel.
- cmd_valid is ignored outside IDLE. The upstream producer must hold its command until cmd_ready.
- Reset (any state, including mid-WAIT or RESULT): state = IDLE, acc = 0, alu_b = 0, alu_sel = 0, cnt = 0, last_q = 0. The in-flight operation is discarded without capture.
- Reset output values: cmd_ready = 1, res_valid = 0, busy = 0, alu_a = 0, alu_b = 0, alu_sel = 0, res_data = 0, res_zero = 1.

## Timing
- Command accepted at edge T:
  - Operation: alu ports change after T; acc captures at edge T+SETTLE; cmd_ready is high again in the cycle after that edge.
  - Load: acc updates at edge T; cmd_ready is high in the next cycle, or res_valid is high there if last.
- res_valid rises in the cycle following capture of a last operation. Latency from command accept to res_valid is SETTLE+1 cycles.
- Back-to-back operation throughput: one command per SETTLE+1 cycles.
- Result accepted at edge R: cmd_ready = 1 in cycle R+1. There is no combinational path from res_ready to cmd_ready.
- alu_a/alu_b/alu_sel are driven directly from registers (glitch-free). alu_out is sampled only at the capture edge.

## Configuration
- ALU_SEQ_ZERO_FLAG_EN.
  - Defined: adds registered output res_zero = (acc == 0), updated at every acc write; reset value 1.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package alu_seq_pkg holds: the state enum (IDLE/WAIT/RESULT), the default WIDTH, and the SETTLE counter width (3).
- Single module. No sub-module; the companion ALU is instantiated beside it, not inside it.

## Test plan
All scenarios use a bench ALU stub returning (A+B) mod 32 for every select, WIDTH = 5, SETTLE = 1.
- Reset, then load 5'd7 with last -> res_valid in the next cycle with res_data = 7; busy = 1 until res_ready.
- Load 7 (not last), then op B = 30, sel = 2'b11, last -> alu_sel = 2'b11 during WAIT; res_data = 5 (wrap) with res_valid two cycles after the op accept.
- Chain of ops B = 1, 2, 3 from acc = 0 with cmd_valid held high -> cmd_ready pulses every second cycle; final res_data = 6.
- res_ready held low for 5 cycles -> res_valid and res_data stay stable, cmd_ready stays 0, and the stray cmd_valid is ignored.
- rst asserted in WAIT -> next cycle: acc = 0, cmd_ready = 1, no res_valid; the aborted op never appears.
- With ALU_SEQ_ZERO_FLAG_EN: load 31, op B = 1, last -> res_data = 0, res_zero = 1; then load 4 -> res_zero = 0.
